// File: rtl/seq_datapath_if.sv
// ---------------------------------------------------------------------------
// seq_datapath_if
//   Command/status bundle between a controller and seq_datapath.
//   master : the controller. It drives start, the command fields, mdata and pc.
//   slave  : the datapath. It drives ready, done, result, data_address, N, V, Z.
// Signals
//   start/ready/done      : command handshake and writeback pulse
//   rd, rn, rm            : destination / operand register indices (RW bits)
//   op, shift             : ALU operation and B-operand shift
//   zero_a, use_imm, imm  : ALU input overrides and immediate
//   wsel, wen             : writeback source select and enable
//   mdata, pc             : memory read data and program counter
//   result, data_address  : C and M registers
//   N, V, Z               : status register
// ---------------------------------------------------------------------------
interface seq_datapath_if #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   parameter int AW    = 9
);
   localparam int RW = $clog2(NREG);

   logic             start;
   logic             ready;
   logic             done;
   logic [RW-1:0]    rd;
   logic [RW-1:0]    rn;
   logic [RW-1:0]    rm;
   logic [1:0]       op;
   logic [1:0]       shift;
   logic             zero_a;
   logic             use_imm;
   logic [WIDTH-1:0] imm;
   logic [1:0]       wsel;
   logic             wen;
   logic [WIDTH-1:0] mdata;
   logic [AW-1:0]    pc;
   logic [WIDTH-1:0] result;
   logic [AW-1:0]    data_address;
   logic             N;
   logic             V;
   logic             Z;

   modport master (
      output start, rd, rn, rm, op, shift, zero_a, use_imm, imm, wsel, wen, mdata, pc,
      input  ready, done, result, data_address, N, V, Z
   );

   modport slave (
      input  start, rd, rn, rm, op, shift, zero_a, use_imm, imm, wsel, wen, mdata, pc,
      output ready, done, result, data_address, N, V, Z
   );
endinterface

// File: rtl/seq_datapath.sv
// ---------------------------------------------------------------------------
// seq_datapath
//   Self-sequencing register-file datapath. Each accepted command runs
//   IDLE -> READ -> EXEC -> WB -> IDLE, one state per cycle:
//     READ : A/B operand registers load from the register file
//     EXEC : the ALU result loads into C and M, and the flags load into N/V/Z
//     WB   : optional register write from C, mdata, imm or pc. done is high.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_datapath_if.slave (command, handshake and status signals)
// ---------------------------------------------------------------------------
module seq_datapath #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   parameter int AW    = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_datapath_if.slave bus
);
   localparam int RW = $clog2(NREG);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;

   localparam logic [1:0] SH_LSL = 2'b01;
   localparam logic [1:0] SH_LSR = 2'b10;
   localparam logic [1:0] SH_ASR = 2'b11;

   localparam logic [1:0] WB_MDATA = 2'b01;
   localparam logic [1:0] WB_IMM   = 2'b10;
   localparam logic [1:0] WB_PC    = 2'b11;

   typedef struct packed {
      logic [RW-1:0]    rd;
      logic [RW-1:0]    rn;
      logic [RW-1:0]    rm;
      logic [1:0]       op;
      logic [1:0]       shift;
      logic             zero_a;
      logic             use_imm;
      logic [WIDTH-1:0] imm;
      logic [1:0]       wsel;
      logic             wen;
      logic [AW-1:0]    pc;
   } cmd_t;

   state_t           state;
   cmd_t             cmd;
   logic             ready_q;
   logic             done_q;
   logic [WIDTH-1:0] regs [NREG];
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] c_q;
   logic [AW-1:0]    m_q;
   logic             n_q;
   logic             v_q;
   logic             z_q;

   logic [WIDTH-1:0] b_shift;
   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] alu;
   logic             alu_v;
   logic [WIDTH-1:0] pc_ext;
   logic [WIDTH-1:0] wb_data;

   // ALU and writeback mux. These act only on the captured command, so the
   // controller may change its inputs freely while a command is in flight.
   // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      b_shift = b_q;
      unique case (cmd.shift)
         SH_LSL:  b_shift = {b_q[WIDTH-2:0], 1'b0};
         SH_LSR:  b_shift = {1'b0, b_q[WIDTH-1:1]};
         SH_ASR:  b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
         default: b_shift = b_q;
      endcase

      ain = cmd.zero_a  ? '0      : a_q;
      bin = cmd.use_imm ? cmd.imm : b_shift;

      alu   = ~bin;
      alu_v = 1'b0;
      unique case (cmd.op)
         OP_ADD: begin
            alu   = ain + bin;
            alu_v = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu[WIDTH-1] != ain[WIDTH-1]);
         end
         OP_SUB: begin
            alu   = ain - bin;
            alu_v = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu[WIDTH-1] != ain[WIDTH-1]);
         end
         OP_AND:  alu = ain & bin;
         default: alu = ~bin;
      endcase

      // Zero-extend pc without a replication count that would be zero when AW == WIDTH.
      pc_ext         = '0;
      pc_ext[AW-1:0] = cmd.pc;

      unique case (cmd.wsel)
         WB_MDATA: wb_data = bus.mdata;
         WB_IMM:   wb_data = cmd.imm;
         WB_PC:    wb_data = pc_ext;
         default:  wb_data = c_q;
      endcase
   end

   // Sequencer and all architectural state. ready/done are registered so that
   // they track state exactly: ready in IDLE only, and done in WB only.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         cmd     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         m_q     <= '0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         // NOTE: the register file is architecturally zero after reset, so it is reset like flops, not left as RAM.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  cmd <= '{rd: bus.rd, rn: bus.rn, rm: bus.rm, op: bus.op,
                           shift: bus.shift, zero_a: bus.zero_a,
                           use_imm: bus.use_imm, imm: bus.imm,
                           wsel: bus.wsel, wen: bus.wen, pc: bus.pc};
                  ready_q <= 1'b0;
                  state   <= S_READ;
               end
            end
            S_READ: begin
               // Operands are read before writeback, so rd aliasing rn/rm sees old values.
               a_q   <= regs[cmd.rn];
               b_q   <= regs[cmd.rm];
               state <= S_EXEC;
            end
            S_EXEC: begin
               c_q    <= alu;
               m_q    <= alu[AW-1:0];
               n_q    <= alu[WIDTH-1];
               v_q    <= alu_v;
               z_q    <= (alu == '0);
               done_q <= 1'b1;
               state  <= S_WB;
            end
            S_WB: begin
               if (cmd.wen) regs[cmd.rd] <= wb_data;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ready        = ready_q;
   assign bus.done         = done_q;
   assign bus.result       = c_q;
   assign bus.data_address = m_q;
   assign bus.N            = n_q;
   assign bus.V            = v_q;
   assign bus.Z            = z_q;
endmodule

// File: tb/tb_seq_datapath.sv
// ---------------------------------------------------------------------------
// tb_seq_datapath
//   Directed bench for seq_datapath (WIDTH=16, NREG=8, AW=9). Commands are
//   driven on the falling edge. Outputs are sampled on the falling edge.
//   Register contents are read back with a "pass B" command:
//   ADD with zero_a=1, shift=00 and wen=0, so that result equals reg[rm].
// ---------------------------------------------------------------------------
module tb_seq_datapath;
   localparam int WIDTH = 16;
   localparam int NREG  = 8;
   localparam int AW    = 9;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   seq_datapath_if #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) bus ();

   seq_datapath #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", bus.ready, 1'b1);
   endtask

   // Runs one full command and checks done/ready timing along the way.
   // mdata holds ~md until the WB cycle and then changes to md. pc is
   // scrambled after the accept edge.
   task automatic run_cmd(input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                          input logic [1:0] op, input logic [1:0] sh, input logic za,
                          input logic ui, input logic [15:0] imm, input logic [1:0] ws,
                          input logic we, input logic [15:0] md, input logic [8:0] pcv);
      @(negedge clk);
      wait_ready();
      bus.rd = rd; bus.rn = rn; bus.rm = rm; bus.op = op; bus.shift = sh;
      bus.zero_a = za; bus.use_imm = ui; bus.imm = imm; bus.wsel = ws;
      bus.wen = we; bus.mdata = ~md; bus.pc = pcv;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.pc    = ~pcv;
      @(negedge clk);
      check("done_read", bus.done, 1'b0);
      @(negedge clk);
      check("done_exec", bus.done, 1'b0);
      @(negedge clk);
      check("done_wb", bus.done, 1'b1);
      check("ready_wb", bus.ready, 1'b0);
      bus.mdata = md;
      @(negedge clk);
      check("ready_idle", bus.ready, 1'b1);
   endtask

   task automatic load_imm(input logic [2:0] rd, input logic [15:0] v);
      run_cmd(rd, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, v, 2'b10, 1'b1, 16'h0, 9'h0);
   endtask

   task automatic read_reg(input logic [2:0] idx, output logic [15:0] v);
      run_cmd(3'd0, 3'd0, idx, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 9'h0);
      v = bus.result;
   endtask

   initial begin
      logic [15:0] r;
      logic        ready_exp [8];
      logic        done_exp  [8];

      rst_n = 1'b0;
      bus.start = 1'b0; bus.rd = '0; bus.rn = '0; bus.rm = '0; bus.op = '0;
      bus.shift = '0; bus.zero_a = 1'b0; bus.use_imm = 1'b0; bus.imm = '0;
      bus.wsel = '0; bus.wen = 1'b0; bus.mdata = '0; bus.pc = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", bus.ready, 1'b1);
      check("rst_done", bus.done, 1'b0);
      check("rst_result", bus.result, 16'h0);
      check("rst_nvz", {bus.N, bus.V, bus.Z}, 3'b000);
      rst_n = 1'b1;

      // Reset pulse in the middle of EXEC discards the command and clears the registers.
      load_imm(3'd1, 16'h0055);
      @(negedge clk);
      bus.rd = 3'd2; bus.rn = 3'd1; bus.rm = 3'd1; bus.op = 2'b00; bus.shift = 2'b00;
      bus.zero_a = 1'b0; bus.use_imm = 1'b0; bus.wsel = 2'b00; bus.wen = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ready", bus.ready, 1'b1);
      check("midrst_done", bus.done, 1'b0);
      check("midrst_result", bus.result, 16'h0);
      check("midrst_addr", bus.data_address, 9'h0);
      check("midrst_nvz", {bus.N, bus.V, bus.Z}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NREG; i++) begin
         read_reg(3'(i), r);
         check($sformatf("rst_reg%0d", i), r, 16'h0);
      end

      // Load and add with an LSL1 on B: 7 + (5<<1) = 17.
      load_imm(3'd1, 16'd7);
      read_reg(3'd1, r); check("r1_7", r, 16'd7);
      load_imm(3'd2, 16'd5);
      run_cmd(3'd3, 3'd1, 3'd2, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 16'h0, 9'h0);
      check("add_result", bus.result, 16'd17);
      check("add_addr", bus.data_address, 9'd17);
      check("add_nvz", {bus.N, bus.V, bus.Z}, 3'b000);
      read_reg(3'd3, r); check("r3_17", r, 16'd17);

      // Signed overflow on ADD.
      load_imm(3'd1, 16'h7FFF);
      load_imm(3'd2, 16'h0001);
      run_cmd(3'd0, 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 9'h0);
      check("ovf_result", bus.result, 16'h8000);
      check("ovf_nvz", {bus.N, bus.V, bus.Z}, 3'b110);

      // AND with immediate: 0x7FFF & 0x0FF0.
      run_cmd(3'd0, 3'd1, 3'd0, 2'b10, 2'b00, 1'b0, 1'b1, 16'h0FF0, 2'b00, 1'b0, 16'h0, 9'h0);
      check("and_result", bus.result, 16'h0FF0);
      check("and_nvz", {bus.N, bus.V, bus.Z}, 3'b000);

      // Compare equal values with SUB and no writeback: R3 keeps 17.
      load_imm(3'd1, 16'h1234);
      load_imm(3'd2, 16'h1234);
      run_cmd(3'd3, 3'd1, 3'd2, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 9'h0);
      check("cmp_result", bus.result, 16'h0);
      check("cmp_nvz", {bus.N, bus.V, bus.Z}, 3'b001);
      read_reg(3'd3, r); check("cmp_r3_kept", r, 16'd17);

      // Shifts and MVN on R4 = 0x8001.
      load_imm(3'd4, 16'h8001);
      run_cmd(3'd0, 3'd0, 3'd4, 2'b11, 2'b11, 1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 9'h0);
      check("mvn_asr", bus.result, 16'h3FFF);
      run_cmd(3'd0, 3'd0, 3'd4, 2'b00, 2'b10, 1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 9'h0);
      check("lsr_bin", bus.result, 16'h4000);
      run_cmd(3'd0, 3'd0, 3'd4, 2'b00, 2'b01, 1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 9'h0);
      check("lsl_bin", bus.result, 16'h0002);
      check("lsl_nvz", {bus.N, bus.V, bus.Z}, 3'b000);

      // SUB overflow: 0x8001 - 2 = 0x7FFF.
      run_cmd(3'd0, 3'd4, 3'd0, 2'b01, 2'b00, 1'b0, 1'b1, 16'h0002, 2'b00, 1'b0, 16'h0, 9'h0);
      check("subv_result", bus.result, 16'h7FFF);
      check("subv_nvz", {bus.N, bus.V, bus.Z}, 3'b010);

      // Handshake with start held high: busy for three cycles, one accept every four.
      // The command fields change after the first accept. That change must not
      // affect the first command and must be picked up by the second.
      for (int i = 0; i < 8; i++) begin
         ready_exp[i] = ((i % 4) == 3);
         done_exp[i]  = ((i % 4) == 2);
      end
      @(negedge clk);
      wait_ready();
      bus.rd = 3'd6; bus.imm = 16'h0011; bus.wsel = 2'b10; bus.wen = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.rd = 3'd7; bus.imm = 16'h0022;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("hs_ready%0d", i), bus.ready, ready_exp[i]);
         check($sformatf("hs_done%0d", i), bus.done, done_exp[i]);
      end
      bus.start = 1'b0;
      read_reg(3'd6, r); check("hs_r6", r, 16'h0011);
      read_reg(3'd7, r); check("hs_r7", r, 16'h0022);

      // Writeback sources, and rd aliasing rn/rm.
      run_cmd(3'd6, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, 1'b1, 16'hBEEF, 9'h0);
      read_reg(3'd6, r); check("wb_mdata", r, 16'hBEEF);
      run_cmd(3'd7, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 2'b11, 1'b1, 16'h0, 9'h1A5);
      read_reg(3'd7, r); check("wb_pc", r, 16'h01A5);
      load_imm(3'd5, 16'd3);
      run_cmd(3'd5, 3'd5, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 16'h0, 9'h0);
      read_reg(3'd5, r); check("alias_r5", r, 16'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
